score_updater: RTL and testbench

- Scores the player in the recorder game by comparing the detected pitch flags from the FFT note detector against the note the song currently expects.
- Outputs a registered hit flag, a registered copy of the expected note, and a 64-bit running score.
- Sits between the song/chart sequencer, which supplies currentNote, and the display/score overlay.

---
 rtl/note_pkg.sv | 14 +
 rtl/score_updater_if.sv | 17 +
 rtl/note_matcher.sv | 16 +
 rtl/score_updater.sv | 51 +++++
 tb/tb_score_updater.sv | 118 +++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// note_pkg: note codes and score width shared by the score updater slice.
package note_pkg;
    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_C    = 3'd1,
        NOTE_D    = 3'd2,
        NOTE_E    = 3'd3,
        NOTE_F    = 3'd4,
        NOTE_G    = 3'd5,
        NOTE_A    = 3'd6,
        NOTE_B    = 3'd7
    } note_e;
    localparam int SCORE_W = 64;
endpackage

// File: rtl/score_updater_if.sv
// score_updater_if: chart note and pitch flags in, hit/note/score out.
interface score_updater_if;
    import note_pkg::*;
    logic [3:1]         currentNote;
    logic               A, As, B, Bs, C, Cs, D, Ds, E, Es, F, Fs, G, Gs;
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic [3:1]         note;
    modport master (
        output currentNote, A, As, B, Bs, C, Cs, D, Ds, E, Es, F, Fs, G, Gs,
        input  hit, score, note
    );
    modport slave (
        input  currentNote, A, As, B, Bs, C, Cs, D, Ds, E, Es, F, Fs, G, Gs,
        output hit, score, note
    );
endinterface

// File: rtl/note_matcher.sv
// note_matcher: selects the natural-note flag named by the chart note.
module note_matcher
    import note_pkg::*;
(
    input  logic [3:1] i_note,
    input  logic [7:1] i_nat,
    input  logic [6:0] i_sharp,
    output logic       o_match
);
    logic [7:0] w_sel;
    // sharps can never satisfy a natural target; they are accepted but ignored
    logic       w_unused_sharp;
    assign w_sel          = {i_nat, 1'b0};
    assign w_unused_sharp = |i_sharp;
    assign o_match        = (i_note != NOTE_REST) && w_sel[i_note];
endmodule

// File: rtl/score_updater.sv
// score_updater: registers hit/note and adds POINTS per SCORE_PERIOD
// consecutive matching cycles, saturating at all-ones.
module score_updater
    import note_pkg::*;
#(
    parameter logic [SCORE_W-1:0] POINTS       = 64'd1,
    parameter int                 SCORE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              reset,
    score_updater_if.slave    bus
);
    localparam int CW = $clog2(SCORE_PERIOD) + 1;
    logic               w_match;
    logic               w_wrap;
    logic [SCORE_W:0]   w_sum;
    logic [CW-1:0]      r_cnt;
    logic               r_hit;
    logic [3:1]         r_note;
    logic [SCORE_W-1:0] r_score;
    note_matcher u_match (
        .i_note  (bus.currentNote),
        .i_nat   ({bus.B, bus.A, bus.G, bus.F, bus.E, bus.D, bus.C}),
        .i_sharp ({bus.As, bus.Bs, bus.Cs, bus.Ds, bus.Es, bus.Fs, bus.Gs}),
        .o_match (w_match)
    );
    assign w_wrap = r_cnt == CW'(SCORE_PERIOD - 1);
    assign w_sum  = {1'b0, r_score} + {1'b0, POINTS};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_note  <= '0;
            r_score <= '0;
        end else begin
            r_hit  <= w_match;
            r_note <= bus.currentNote;
            if (!w_match) begin
                r_cnt <= '0;
            end else if (w_wrap) begin
                r_cnt   <= '0;
                r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
    assign bus.hit   = r_hit;
    assign bus.note  = r_note;
    assign bus.score = r_score;
endmodule

// File: tb/tb_score_updater.sv
// tb_score_updater: directed checks on three configurations fed the same stimulus.
module tb_score_updater;
    import note_pkg::*;
    localparam logic [63:0] MAX  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BIGP = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam int F_A = 13, F_As = 12, F_B = 11, F_C = 9, F_Cs = 8, F_Gs = 0;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:1]  t_note = '0;
    logic [13:0] t_flags = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    always #5 clk = ~clk;
    score_updater_if ia ();
    score_updater_if ib ();
    score_updater_if ic ();
    assign ia.currentNote = t_note;
    assign ib.currentNote = t_note;
    assign ic.currentNote = t_note;
    assign {ia.A, ia.As, ia.B, ia.Bs, ia.C, ia.Cs, ia.D, ia.Ds, ia.E, ia.Es, ia.F, ia.Fs, ia.G, ia.Gs} = t_flags;
    assign {ib.A, ib.As, ib.B, ib.Bs, ib.C, ib.Cs, ib.D, ib.Ds, ib.E, ib.Es, ib.F, ib.Fs, ib.G, ib.Gs} = t_flags;
    assign {ic.A, ic.As, ic.B, ic.Bs, ic.C, ic.Cs, ic.D, ic.Ds, ic.E, ic.Es, ic.F, ic.Fs, ic.G, ic.Gs} = t_flags;
    score_updater #(.POINTS(64'd1), .SCORE_PERIOD(1000)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    score_updater #(.POINTS(64'd1), .SCORE_PERIOD(4))    dut_b (.clk(clk), .reset(reset), .bus(ib));
    score_updater #(.POINTS(BIGP),  .SCORE_PERIOD(1))    dut_c (.clk(clk), .reset(reset), .bus(ic));
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        t_note = 3'(NOTE_C);
        t_flags[F_C] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(10);
            check("rst_hit", {63'd0, ia.hit}, 64'd0);
            check("rst_note", {61'd0, ia.note}, 64'd0);
            check("rst_score_c", ic.score, 64'd0);
        end
        reset = 1'b1;
        tick(1);
        check("hold_hit", {63'd0, ia.hit}, 64'd1);
        check("hold_note", {61'd0, ia.note}, 64'd1);
        check("a_score_1", ia.score, 64'd0);
        check("c_first", ic.score, BIGP);
        tick(1);
        check("c_sat", ic.score, MAX);
        tick(1);
        check("c_sat_hold", ic.score, MAX);
        check("b_score_3", ib.score, 64'd0);
        tick(1);
        check("b_score_4", ib.score, 64'd1);
        tick(995);
        check("a_score_999", ia.score, 64'd0);
        tick(1);
        check("a_score_1000", ia.score, 64'd1);
        tick(4000);
        check("a_score_5000", ia.score, 64'd5);
        check("b_score_5000", ib.score, 64'd1250);
        t_note = 3'(NOTE_REST);
        tick(1);
        check("rest_hit", {63'd0, ia.hit}, 64'd0);
        check("rest_note", {61'd0, ia.note}, 64'd0);
        check("rest_score", ia.score, 64'd5);
        t_note = 3'(NOTE_C);
        tick(3);
        t_note = 3'(NOTE_REST);
        tick(1);
        t_note = 3'(NOTE_C);
        tick(3);
        check("b_interrupt_3", ib.score, 64'd1250);
        tick(1);
        check("b_interrupt_4", ib.score, 64'd1251);
        t_note = 3'(NOTE_A);
        t_flags = '0;
        t_flags[F_Gs] = 1'b1;
        t_flags[F_As] = 1'b1;
        t_flags[F_B]  = 1'b1;
        t_flags[F_Cs] = 1'b1;
        tick(200);
        check("sharp_hit", {63'd0, ia.hit}, 64'd0);
        check("sharp_score_a", ia.score, 64'd5);
        check("sharp_score_b", ib.score, 64'd1251);
        check("sat_kept", ic.score, MAX);
        t_flags[F_A] = 1'b1;
        tick(1);
        check("a_hit", {63'd0, ia.hit}, 64'd1);
        check("a_note", {61'd0, ia.note}, 64'd6);
        tick(1);
        t_flags[F_C] = 1'b1;
        t_note = 3'(NOTE_C);
        tick(1);
        check("chg_b_3", ib.score, 64'd1251);
        tick(1);
        check("chg_b_4", ib.score, 64'd1252);
        #2 reset = 1'b0;
        #1;
        check("async_score_a", ia.score, 64'd0);
        check("async_score_c", ic.score, 64'd0);
        check("async_hit", {63'd0, ia.hit}, 64'd0);
        #2 reset = 1'b1;
        tick(1);
        check("post_hit", {63'd0, ia.hit}, 64'd1);
        check("post_c", ic.score, BIGP);
        tick(2);
        check("post_b_3", ib.score, 64'd0);
        tick(1);
        check("post_b_4", ib.score, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
